// File: rtl/gnt_burst_pkg.sv
// Shared types and helpers for the grant-driven burst controller.
// Holds the FSM encoding and the one-hot grant decode used by the decoder.
package gnt_burst_pkg;

    localparam int ID_W    = 2;
    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        XFER      = 2'd1,
        DONE      = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    // Returns {valid, id}; valid only when exactly one grant bit is set.
    function automatic logic [ID_W:0] onehot4(input logic [NUM_REQ-1:0] g);
        logic [ID_W:0] r;
        r = '0;
        case (g)
            4'b0001: r = {1'b1, 2'd0};
            4'b0010: r = {1'b1, 2'd1};
            4'b0100: r = {1'b1, 2'd2};
            4'b1000: r = {1'b1, 2'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gnt_onehot_dec.sv
// Decodes the arbiter's 4-bit grant vector into a single-grant valid/id pair
// and flags any cycle where more than one grant is high.
module gnt_onehot_dec
    import gnt_burst_pkg::*;
(
    input  logic [NUM_REQ-1:0] gnt,
    output logic               valid,
    output logic               multi,
    output logic [ID_W-1:0]    id
);

    logic [ID_W:0] dec;

    assign dec   = onehot4(gnt);
    assign valid = dec[ID_W];
    assign id    = dec[ID_W-1:0];
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (gnt & (gnt - NUM_REQ'(1))) != '0;

endmodule

// File: rtl/gnt_burst_ctrl.sv
// Moves a burst of len_N beats from the granted requester onto one valid/ready
// output, then pulses done_N and waits for the grant to drop before re-arming.
module gnt_burst_ctrl
    import gnt_burst_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BEAT_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt_0,
    input  logic              gnt_1,
    input  logic              gnt_2,
    input  logic              gnt_3,
    input  logic [BEAT_W-1:0] len_0,
    input  logic [BEAT_W-1:0] len_1,
    input  logic [BEAT_W-1:0] len_2,
    input  logic [BEAT_W-1:0] len_3,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    output logic              beat_rd_0,
    output logic              beat_rd_1,
    output logic              beat_rd_2,
    output logic              beat_rd_3,
    output logic              done_0,
    output logic              done_1,
    output logic              done_2,
    output logic              done_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic              out_last,
    output logic              err_onehot,
    output logic              err_timeout,
    output logic [1:0]        dbg_state
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(TIMEOUT - 1);

    logic [NUM_REQ-1:0] gnt;
    logic [BEAT_W-1:0]  len_arr  [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];

    assign gnt      = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign len_arr  = '{len_0, len_1, len_2, len_3};
    assign data_arr = '{data_0, data_1, data_2, data_3};

    logic            gnt_valid;
    logic            gnt_multi;
    logic [ID_W-1:0] gnt_id;

    gnt_onehot_dec u_dec (
        .gnt   (gnt),
        .valid (gnt_valid),
        .multi (gnt_multi),
        .id    (gnt_id)
    );

    state_t             state;
    logic [ID_W-1:0]    id;
    logic [BEAT_W-1:0]  remaining;
    logic [STALL_W-1:0] stall_cnt;
    logic [NUM_REQ-1:0] done_q;
    logic [NUM_REQ-1:0] beat_rd;
    logic               id_gnt;
    logic               hs;

    // Valid/ready: a beat moves in any cycle where out_valid and out_ready are
    // both high; out_valid, once raised, holds until that handshake (or an
    // abort/timeout), and out_data must not change while it waits.
    assign id_gnt = gnt[id];
    assign hs     = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            id          <= '0;
            remaining   <= '0;
            stall_cnt   <= '0;
            done_q      <= '0;
            out_valid   <= 1'b0;
            err_onehot  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done_q <= '0;
            if (gnt_multi) begin
                err_onehot <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        id        <= gnt_id;
                        remaining <= len_arr[gnt_id];
                        stall_cnt <= '0;
                        if (len_arr[gnt_id] != '0) begin
                            state     <= XFER;
                            out_valid <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= NUM_REQ'(1) << gnt_id;
                        end
                    end
                end
                XFER: begin
                    if (hs && remaining != '0) begin
                        remaining <= remaining - 1'b1;
                    end
                    // A withdrawn grant wins over everything else: quietly abandon.
                    if (!id_gnt) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        stall_cnt <= '0;
                    end else if (hs) begin
                        stall_cnt <= '0;
                        if (remaining == BEAT_W'(1)) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done_q    <= NUM_REQ'(1) << id;
                        end
                    end else if (stall_cnt == STALL_LIM) begin
                        err_timeout <= 1'b1;
                        state       <= DONE;
                        out_valid   <= 1'b0;
                        stall_cnt   <= '0;
                        done_q      <= NUM_REQ'(1) << id;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!id_gnt) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign beat_rd   = hs ? (NUM_REQ'(1) << id) : '0;
    assign beat_rd_0 = beat_rd[0];
    assign beat_rd_1 = beat_rd[1];
    assign beat_rd_2 = beat_rd[2];
    assign beat_rd_3 = beat_rd[3];

    assign done_0 = done_q[0];
    assign done_1 = done_q[1];
    assign done_2 = done_q[2];
    assign done_3 = done_q[3];

    // Data is gated so the bus reads zero whenever no beat is offered.
    assign out_data  = out_valid ? data_arr[id] : '0;
    assign out_id    = id;
    assign out_last  = out_valid && (remaining == BEAT_W'(1));
    assign dbg_state = state;

endmodule

// File: tb/tb_gnt_burst_ctrl.sv
// Directed bench for gnt_burst_ctrl: expected beats are queued when a burst is
// set up and popped by a monitor as each handshake happens.
module tb_gnt_burst_ctrl;
    import gnt_burst_pkg::*;

    localparam int DATA_W  = 8;
    localparam int BEAT_W  = 4;
    localparam int TIMEOUT = 15;
    localparam int EW      = 2 + 1 + DATA_W;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        gnt_v = '0;
    logic [BEAT_W-1:0] len_v  [4];
    logic [DATA_W-1:0] data_v [4];
    logic              out_ready = 1'b0;

    logic              beat_rd_0, beat_rd_1, beat_rd_2, beat_rd_3;
    logic              done_0, done_1, done_2, done_3;
    logic              out_valid, out_last, err_onehot, err_timeout;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_id;
    logic [1:0]        dbg_state;
    logic [3:0]        beat_v, done_v;

    assign beat_v = {beat_rd_3, beat_rd_2, beat_rd_1, beat_rd_0};
    assign done_v = {done_3, done_2, done_1, done_0};

    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] src_q[4][$];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gnt_burst_ctrl #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .gnt_0       (gnt_v[0]),
        .gnt_1       (gnt_v[1]),
        .gnt_2       (gnt_v[2]),
        .gnt_3       (gnt_v[3]),
        .len_0       (len_v[0]),
        .len_1       (len_v[1]),
        .len_2       (len_v[2]),
        .len_3       (len_v[3]),
        .data_0      (data_v[0]),
        .data_1      (data_v[1]),
        .data_2      (data_v[2]),
        .data_3      (data_v[3]),
        .beat_rd_0   (beat_rd_0),
        .beat_rd_1   (beat_rd_1),
        .beat_rd_2   (beat_rd_2),
        .beat_rd_3   (beat_rd_3),
        .done_0      (done_0),
        .done_1      (done_1),
        .done_2      (done_2),
        .done_3      (done_3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_last    (out_last),
        .err_onehot  (err_onehot),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({out_valid, out_last, out_id, out_data, done_v, beat_v,
                    err_onehot, err_timeout, dbg_state});
    endfunction

    // Head beat goes straight onto data_N; the rest wait in src_q until popped.
    task automatic load_burst(input int n, input int beats);
        logic [DATA_W-1:0] v;
        src_q[n].delete();
        len_v[n] = BEAT_W'(beats);
        for (int k = 0; k < beats; k++) begin
            v = DATA_W'($urandom_range(0, 255));
            if (k == 0) data_v[n] = v;
            else        src_q[n].push_back(v);
            exp_q.push_back({2'(n), (k == beats - 1), v});
        end
    endtask

    always @(negedge clock) begin : mon
        logic [EW-1:0] e;
        int n;
        #3;
        if (out_valid && out_ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = int'(e[EW-1 -: 2]);
                chk("beat_payload", 32'({out_id, out_last, out_data}), 32'(e));
                chk("beat_rd_strobe", 32'(beat_v), 32'(4'b0001 << n));
                @(posedge clock);
                #1;
                if (src_q[n].size() != 0) data_v[n] = src_q[n].pop_front();
                else                      data_v[n] = DATA_W'($urandom_range(0, 255));
            end
        end else begin
            chk("beat_rd_idle", 32'(beat_v), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            len_v[i]  = '0;
            data_v[i] = DATA_W'($urandom_range(0, 255));
        end

        // Reset state
        repeat (2) @(negedge clock);
        #1 chk("reset_outputs", outs(), 32'd0);
        @(negedge clock); reset = 1'b1;

        // Three-beat burst from requester 1 with a lingering grant
        @(negedge clock); load_burst(1, 3); gnt_v = 4'b0010; out_ready = 1'b1;
        #1 chk("t2_no_valid_yet", 32'(out_valid), 32'd0);
        @(negedge clock);
        #1 chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_state_xfer", 32'(dbg_state), 32'(XFER));
        chk("t2_last_b1", 32'(out_last), 32'd0);
        @(negedge clock);
        #1 chk("t2_last_b2", 32'(out_last), 32'd0);
        @(negedge clock);
        #1 chk("t2_last_b3", 32'(out_last), 32'd1);
        @(negedge clock);
        #1 chk("t2_done", 32'(done_v), 32'b0010);
        chk("t2_valid_off", 32'(out_valid), 32'd0);
        @(negedge clock);
        #1 chk("t2_done_once", 32'(done_v), 32'd0);
        chk("t2_wait_drop", 32'(dbg_state), 32'(WAIT_DROP));
        @(negedge clock);
        #1 chk("t2_no_restart", 32'(out_valid), 32'd0);
        chk("t2_still_wait", 32'(dbg_state), 32'(WAIT_DROP));
        gnt_v = 4'b0000;
        @(negedge clock);
        #1 chk("t2_idle", 32'(dbg_state), 32'(IDLE));
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero-beat burst
        @(negedge clock); len_v[0] = '0; gnt_v = 4'b0001;
        @(negedge clock);
        #1 chk("t3_done", 32'(done_v), 32'b0001);
        chk("t3_no_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        #1 chk("t3_wait_drop", 32'(dbg_state), 32'(WAIT_DROP));
        chk("t3_done_once", 32'(done_v), 32'd0);
        gnt_v = 4'b0000;
        @(negedge clock);
        #1 chk("t3_idle", 32'(dbg_state), 32'(IDLE));

        // Stalled sink forces a timeout
        @(negedge clock); load_burst(3, 2); gnt_v = 4'b1000; out_ready = 1'b0;
        repeat (15) @(negedge clock);
        #1 chk("t4_still_valid", 32'(out_valid), 32'd1);
        chk("t4_no_timeout_yet", 32'(err_timeout), 32'd0);
        @(negedge clock);
        #1 chk("t4_timeout", 32'(err_timeout), 32'd1);
        chk("t4_done", 32'(done_v), 32'b1000);
        chk("t4_valid_off", 32'(out_valid), 32'd0);
        @(negedge clock);
        #1 chk("t4_wait_drop", 32'(dbg_state), 32'(WAIT_DROP));
        gnt_v = 4'b0000;
        @(negedge clock);
        #1 chk("t4_idle", 32'(dbg_state), 32'(IDLE));
        chk("t4_unread_beats", 32'(exp_q.size()), 32'd2);
        chk("t4_onehot_clear", 32'(err_onehot), 32'd0);
        exp_q.delete();

        // Multi-hot grant in IDLE
        @(negedge clock); gnt_v = 4'b0101; out_ready = 1'b1;
        @(negedge clock);
        #1 chk("t5_onehot_err", 32'(err_onehot), 32'd1);
        chk("t5_idle", 32'(dbg_state), 32'(IDLE));
        chk("t5_no_valid", 32'(out_valid), 32'd0);
        gnt_v = 4'b0000;
        @(negedge clock);
        #1 chk("t5_onehot_sticky", 32'(err_onehot), 32'd1);

        // Grant withdrawn after one of four beats
        @(negedge clock); load_burst(2, 4); gnt_v = 4'b0100; out_ready = 1'b1;
        @(negedge clock);
        #1 chk("t6_valid", 32'(out_valid), 32'd1);
        @(negedge clock); gnt_v = 4'b0000; out_ready = 1'b0;
        #1 chk("t6_valid_hold", 32'(out_valid), 32'd1);
        @(negedge clock);
        #1 chk("t6_abort_valid", 32'(out_valid), 32'd0);
        chk("t6_abort_idle", 32'(dbg_state), 32'(IDLE));
        chk("t6_no_done_a", 32'(done_v), 32'd0);
        @(negedge clock);
        #1 chk("t6_no_done_b", 32'(done_v), 32'd0);
        chk("t6_unread_beats", 32'(exp_q.size()), 32'd3);
        chk("t6_errors_sticky", 32'({err_onehot, err_timeout}), 32'b11);
        exp_q.delete();

        // Asynchronous reset in the middle of a burst
        @(negedge clock); load_burst(2, 4); gnt_v = 4'b0100; out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock); out_ready = 1'b0;
        #1 chk("t1_mid_xfer", 32'(dbg_state), 32'(XFER));
        chk("t1_mid_id", 32'(out_id), 32'd2);
        chk("t1_not_last", 32'(out_last), 32'd0);
        #1 reset = 1'b0;
        #2 chk("t1_async_reset", outs(), 32'd0);
        @(negedge clock); gnt_v = 4'b0000; reset = 1'b1;
        @(negedge clock);
        #1 chk("t1_idle_after", outs(), 32'd0);
        chk("t1_unread_beats", 32'(exp_q.size()), 32'd3);
        exp_q.delete();

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
